// File: rtl/tmr_err_monitor_if.sv
// Bundle of the voter-side error flags and the recovery handshake seen by
// tmr_err_monitor. The master side (voter + recovery controller) drives the
// error vectors and the ack; the slave side (the monitor) drives status and req.
interface tmr_err_monitor_if #(
  parameter int N_ERR = 1
);
  logic             valid_i;
  logic [N_ERR-1:0] err_detected_1_i;
  logic [N_ERR-1:0] err_detected_2_i;
  logic [N_ERR-1:0] err_detected_3_i;
  logic [N_ERR-1:0] err_corrected_i;
  logic [N_ERR-1:0] err_detected_i;
  logic             recover_ack_i;
  logic             recover_req_o;
  logic [1:0]       recover_id_o;
  logic [2:0]       faulty_o;
  logic             fatal_o;
  logic [15:0]      corr_count_o;

  modport master (
    output valid_i, err_detected_1_i, err_detected_2_i, err_detected_3_i,
           err_corrected_i, err_detected_i, recover_ack_i,
    input  recover_req_o, recover_id_o, faulty_o, fatal_o, corr_count_o
  );

  modport slave (
    input  valid_i, err_detected_1_i, err_detected_2_i, err_detected_3_i,
           err_corrected_i, err_detected_i, recover_ack_i,
    output recover_req_o, recover_id_o, faulty_o, fatal_o, corr_count_o
  );
endinterface

// File: rtl/tmr_err_monitor.sv
// TMR error monitor: one leaky saturating error counter per replica, a faulty
// flag per replica at THRESH, one-at-a-time recovery requests over req/ack,
// a sticky fatal flag for uncorrectable disagreement and a saturating count of
// corrected events.
module tmr_err_monitor #(
  parameter int N_ERR       = 1,
  parameter int CNT_W       = 8,
  parameter int THRESH      = 16,
  parameter int LEAK_PERIOD = 1024
) (
  input  logic            clk,
  input  logic            rst,
  tmr_err_monitor_if.slave bus
);

  localparam int               TMR_W     = $clog2(LEAK_PERIOD);
  localparam logic [TMR_W-1:0] LEAK_LAST = TMR_W'(LEAK_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] THRESH_C  = CNT_W'(THRESH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  logic [TMR_W-1:0] leak_tmr_r;
  logic             leak_s;
  logic [2:0]       ev_s;
  logic             ev_c_s;
  logic             ev_f_s;
  logic [CNT_W-1:0] cnt_r      [3];
  logic [CNT_W-1:0] cnt_next_s [3];
  logic [2:0]       faulty_s;
  state_t           state_r;
  state_t           state_next_s;
  logic [1:0]       id_r;
  logic [1:0]       id_next_s;
  logic             req_r;
  logic             fatal_r;
  logic [15:0]      corr_r;

  // Event decode: everything is gated by valid_i so idle cycles carry no events.
  always_comb begin
    ev_s[0] = bus.valid_i & (|bus.err_detected_1_i);
    ev_s[1] = bus.valid_i & (|bus.err_detected_2_i);
    ev_s[2] = bus.valid_i & (|bus.err_detected_3_i);
    ev_c_s  = bus.valid_i & (|(bus.err_detected_i & bus.err_corrected_i));
    ev_f_s  = bus.valid_i & (|(bus.err_detected_i & ~bus.err_corrected_i));
    leak_s  = (leak_tmr_r == LEAK_LAST);
  end

  // Free-running leak timer; wraps after the leak cycle regardless of valid_i.
  always_ff @(posedge clk) begin
    if (rst) begin
      leak_tmr_r <= {TMR_W{1'b0}};
    end else if (leak_s) begin
      leak_tmr_r <= {TMR_W{1'b0}};
    end else begin
      leak_tmr_r <= leak_tmr_r + TMR_W'(1);
    end
  end

  // Per-replica counter next value: clear in CLEAR wins, else event/leak rules.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      cnt_next_s[k] = cnt_r[k];
      if ((state_r == ST_CLEAR) && (id_r == 2'(k))) begin
        cnt_next_s[k] = CNT_ZERO;
      end else if (ev_s[k] && !leak_s) begin
        if (cnt_r[k] != CNT_MAX) begin
          cnt_next_s[k] = cnt_r[k] + CNT_W'(1);
        end else begin
          cnt_next_s[k] = cnt_r[k];
        end
      end else if (!ev_s[k] && leak_s) begin
        if (cnt_r[k] != CNT_ZERO) begin
          cnt_next_s[k] = cnt_r[k] - CNT_W'(1);
        end else begin
          cnt_next_s[k] = cnt_r[k];
        end
      end else begin
        cnt_next_s[k] = cnt_r[k];
      end
    end
  end

  // Faulty flags follow the counters directly so the FSM sees a crossing at once.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      faulty_s[k] = (cnt_r[k] >= THRESH_C);
    end
  end

  // Recovery FSM next-state: serve the lowest faulty replica, one per round.
  always_comb begin
    state_next_s = state_r;
    id_next_s    = id_r;
    case (state_r)
      ST_IDLE: begin
        if (faulty_s != 3'b000) begin
          state_next_s = ST_REQ;
          if (faulty_s[0]) begin
            id_next_s = 2'd0;
          end else if (faulty_s[1]) begin
            id_next_s = 2'd1;
          end else begin
            id_next_s = 2'd2;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus.recover_ack_i) begin
          state_next_s = ST_CLEAR;
        end else begin
          state_next_s = ST_REQ;
        end
      end
      ST_CLEAR: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      id_r    <= 2'd0;
      req_r   <= 1'b0;
      fatal_r <= 1'b0;
      corr_r  <= 16'h0000;
      for (int k = 0; k < 3; k++) begin
        cnt_r[k] <= CNT_ZERO;
      end
    end else begin
      state_r <= state_next_s;
      id_r    <= id_next_s;
      req_r   <= (state_next_s == ST_REQ);
      fatal_r <= fatal_r | ev_f_s;
      if (ev_c_s && (corr_r != 16'hFFFF)) begin
        corr_r <= corr_r + 16'd1;
      end
      for (int k = 0; k < 3; k++) begin
        cnt_r[k] <= cnt_next_s[k];
      end
    end
  end

  assign bus.recover_req_o = req_r;
  assign bus.recover_id_o  = id_r;
  assign bus.faulty_o      = faulty_s;
  assign bus.fatal_o       = fatal_r;
  assign bus.corr_count_o  = corr_r;

endmodule
